// File: rtl/mac_mul_sched_pkg.sv
// Shared constants for the multiplier scheduler: cfg encodings, FSM states,
// lane geometry and the per-cfg lane-enable helper.
package mac_mul_sched_pkg;

  localparam int LANE_W = 8;
  localparam int LANES  = 4;

  localparam logic [1:0] CFG_SINGLE  = 2'b00;
  localparam logic [1:0] CFG_DUAL    = 2'b01;
  localparam logic [1:0] CFG_QUAD    = 2'b10;
  localparam logic [1:0] CFG_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Which A lanes survive the latch; an illegal cfg keeps none.
  function automatic logic [LANES-1:0] lane_mask(input logic [1:0] cfg);
    case (cfg)
      CFG_SINGLE: lane_mask = 4'b0001;
      CFG_DUAL:   lane_mask = 4'b0011;
      CFG_QUAD:   lane_mask = 4'b1111;
      default:    lane_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/mac_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first active request
// at or above the pointer, wrapping to the lowest index.
module mac_rr_arbiter #(
  parameter int N_REQ    = 4,
  parameter int ID_WIDTH = 3
) (
  input  logic [N_REQ-1:0]    req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [N_REQ-1:0]    grant,
  output logic [ID_WIDTH-1:0] grant_idx,
  output logic                any
);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    // First pass covers [ptr, N_REQ-1], second pass wraps to [0, ptr-1].
    for (int i = 0; i < N_REQ; i++) begin
      if (!any && req[i] && (i >= int'(ptr))) begin
        any       = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = ID_WIDTH'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!any && req[i] && (i < int'(ptr))) begin
        any       = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = ID_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/mac_mul_sched.sv
// Round-robin scheduler sharing one lane-configurable multiplier among N_REQ
// requesters; returns the tagged product over a valid/ready channel.
module mac_mul_sched
  import mac_mul_sched_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int MAC_CONF_WIDTH = 2,
  parameter int MAC_MIN_WIDTH  = 8,
  parameter int MAC_INT_WIDTH  = 5 * MAC_MIN_WIDTH,
  parameter int ID_WIDTH       = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_REQ-1:0]                req_valid,
  output logic [N_REQ-1:0]                req_ready,
  input  logic [N_REQ*4*MAC_MIN_WIDTH-1:0] req_a,
  input  logic [N_REQ*MAC_MIN_WIDTH-1:0]  req_b,
  input  logic [N_REQ*MAC_CONF_WIDTH-1:0] req_cfg,
  output logic [MAC_MIN_WIDTH-1:0]        mul_a0,
  output logic [MAC_MIN_WIDTH-1:0]        mul_a1,
  output logic [MAC_MIN_WIDTH-1:0]        mul_a2,
  output logic [MAC_MIN_WIDTH-1:0]        mul_a3,
  output logic [MAC_MIN_WIDTH-1:0]        mul_b0,
  output logic [MAC_CONF_WIDTH-1:0]       mul_cfg,
  input  logic [MAC_INT_WIDTH-1:0]        mul_c,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [MAC_INT_WIDTH-1:0]        out_c,
  output logic [ID_WIDTH-1:0]             out_id,
  output logic                            out_err,
  output logic                            busy,
  output logic [15:0]                     done_cnt
);

  localparam int W = MAC_MIN_WIDTH;

  state_t              state;
  logic [ID_WIDTH-1:0] ptr;
  logic [N_REQ-1:0]    grant;
  logic [ID_WIDTH-1:0] grant_idx;
  logic                any;

  mac_rr_arbiter #(.N_REQ(N_REQ), .ID_WIDTH(ID_WIDTH)) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any)
  );

  assign req_ready = (state == ST_IDLE) ? grant : '0;
  assign busy      = (state != ST_IDLE);

  // One-hot mux of the granted requester's operand set.
  logic [4*W-1:0]            sel_a;
  logic [W-1:0]              sel_b;
  logic [MAC_CONF_WIDTH-1:0] sel_cfg;

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_cfg = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_a   = req_a[i*4*W +: 4*W];
        sel_b   = req_b[i*W +: W];
        sel_cfg = req_cfg[i*MAC_CONF_WIDTH +: MAC_CONF_WIDTH];
      end
    end
  end

  logic           sel_illegal;
  logic [3:0]     lane_en;
  logic [W-1:0]   lane_a [4];
  logic [W-1:0]   lane_b;

  assign sel_illegal = (sel_cfg[1:0] == CFG_ILLEGAL);
  assign lane_en     = lane_mask(sel_cfg[1:0]);
  assign lane_b      = sel_illegal ? '0 : sel_b;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_a[gi] = lane_en[gi] ? sel_a[gi*W +: W] : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      mul_a0    <= '0;
      mul_a1    <= '0;
      mul_a2    <= '0;
      mul_a3    <= '0;
      mul_b0    <= '0;
      mul_cfg   <= '0;
      out_valid <= 1'b0;
      out_c     <= '0;
      out_id    <= '0;
      out_err   <= 1'b0;
      done_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any) begin
            mul_a0  <= lane_a[0];
            mul_a1  <= lane_a[1];
            mul_a2  <= lane_a[2];
            mul_a3  <= lane_a[3];
            mul_b0  <= lane_b;
            mul_cfg <= sel_illegal ? '0 : sel_cfg;
            out_err <= sel_illegal;
            out_id  <= grant_idx;
            ptr     <= (grant_idx == ID_WIDTH'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          out_c     <= out_err ? '0 : mul_c;
          out_valid <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            done_cnt  <= done_cnt + 16'd1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_mul_sched.sv
// Directed bench for mac_mul_sched; a behavioural multiplier drives mul_c as
// {A3,A2,A1,A0} * B0.
module tb_mac_mul_sched;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int CW = 40;
  localparam int IW = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*4*W-1:0] req_a = '0;
  logic [N*W-1:0]  req_b = '0;
  logic [N*2-1:0]  req_cfg = '0;
  logic [W-1:0]    mul_a0, mul_a1, mul_a2, mul_a3, mul_b0;
  logic [1:0]      mul_cfg;
  logic [CW-1:0]   mul_c;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [CW-1:0]   out_c;
  logic [IW-1:0]   out_id;
  logic            out_err;
  logic            busy;
  logic [15:0]     done_cnt;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign mul_c = CW'({mul_a3, mul_a2, mul_a1, mul_a0}) * CW'(mul_b0);

  mac_mul_sched #(
    .N_REQ(N), .MAC_CONF_WIDTH(2), .MAC_MIN_WIDTH(W), .MAC_INT_WIDTH(CW), .ID_WIDTH(IW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cfg(req_cfg),
    .mul_a0(mul_a0), .mul_a1(mul_a1), .mul_a2(mul_a2), .mul_a3(mul_a3),
    .mul_b0(mul_b0), .mul_cfg(mul_cfg), .mul_c(mul_c),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_c(out_c), .out_id(out_id), .out_err(out_err),
    .busy(busy), .done_cnt(done_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [7:0] b,
                         input logic [1:0] cfg);
    req_a[i*32 +: 32] = a;
    req_b[i*8 +: 8]   = b;
    req_cfg[i*2 +: 2] = cfg;
  endtask

  // One isolated transaction: grant check, latched operands, 2-cycle latency,
  // response fields, handshake.
  task automatic run_one(input string tag, input int i, input logic [31:0] exp_mula,
                         input logic [7:0] exp_b, input logic [1:0] exp_cfg,
                         input logic [39:0] exp_c, input logic exp_err,
                         input logic [15:0] exp_cnt);
    req_valid = 4'b0001 << i;
    #1;
    chk({tag, ".grant"}, 64'(req_ready), 64'(4'b0001 << i));
    tick();
    req_valid = '0;
    chk({tag, ".mul_a"}, 64'({mul_a3, mul_a2, mul_a1, mul_a0}), 64'(exp_mula));
    chk({tag, ".mul_b"}, 64'(mul_b0), 64'(exp_b));
    chk({tag, ".mul_cfg"}, 64'(mul_cfg), 64'(exp_cfg));
    chk({tag, ".exec_valid"}, 64'({busy, out_valid, req_ready}), 64'({1'b1, 1'b0, 4'b0000}));
    tick();
    chk({tag, ".valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".out_c"}, 64'(out_c), 64'(exp_c));
    chk({tag, ".out_id_err"}, 64'({out_id, out_err}), 64'({3'(i), exp_err}));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, ".after"}, 64'({busy, out_valid, done_cnt}), 64'({1'b0, 1'b0, exp_cnt}));
    $display("txn %s req=%0d out_c=%0h id=%0d err=%0b cnt=%0d", tag, i, out_c, out_id, out_err, done_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick();
    tick();
    chk("reset.outs", 64'({out_valid, busy, out_err, done_cnt}), 64'd0);
    chk("reset.mul", 64'({mul_a3, mul_a2, mul_a1, mul_a0, mul_b0, mul_cfg}), 64'd0);
    chk("reset.out_c", 64'(out_c), 64'd0);
    rst = 1'b1;
    tick();

    // Upper lanes carry junk that the cfg must mask off
    set_req(0, 32'hAABBCC0F, 8'h03, 2'b00);
    run_one("single", 0, 32'h0000000F, 8'h03, 2'b00, 40'h2D, 1'b0, 16'd1);
    set_req(2, 32'hDEAD1234, 8'h56, 2'b01);
    run_one("dual", 2, 32'h00001234, 8'h56, 2'b01, 40'h61D78, 1'b0, 16'd2);
    set_req(1, 32'hFFFFFFFF, 8'hFF, 2'b10);
    run_one("quad", 1, 32'hFFFFFFFF, 8'hFF, 2'b10, 40'hFEFFFFFF01, 1'b0, 16'd3);
    // Pointer is 2 here; only requester 3 is valid so it wins and pointer wraps to 0
    set_req(3, 32'h11223344, 8'h55, 2'b11);
    run_one("illegal", 3, 32'h0, 8'h00, 2'b00, 40'h0, 1'b1, 16'd4);

    // Fairness: all four pending, out_ready held high
    for (int i = 0; i < N; i++) set_req(i, 32'(i + 1), 8'h10, 2'b00);
    req_valid = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      int e;
      e = k % 4;
      #0;
      chk("fair.grant", 64'(req_ready), 64'(4'b0001 << e));
      tick();
      chk("fair.exec", 64'(out_valid), 64'd0);
      tick();
      chk("fair.resp", 64'({out_valid, out_id, out_c}), 64'({1'b1, 3'(e), 40'((e + 1) * 16)}));
      $display("txn fair k=%0d id=%0d out_c=%0h", k, out_id, out_c);
      tick();
    end
    chk("fair.cnt", 64'(done_cnt), 64'd9);

    // Backpressure: requester 1 is next; hold out_ready low for 5 cycles
    out_ready = 1'b0;
    chk("bp.grant", 64'(req_ready), 64'b0010);
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("bp.hold", 64'({out_valid, req_ready, out_id, out_c}), 64'({1'b1, 4'b0000, 3'd1, 40'h20}));
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    req_valid = '0;
    chk("bp.cnt", 64'({out_valid, done_cnt}), 64'({1'b0, 16'd10}));
    $display("txn backpressure id=1 cnt=%0d", done_cnt);

    // Async reset while in EXEC; pointer was 2 so requester 3 is granted
    req_valid = 4'b1000;
    #1;
    tick();
    chk("rst.in_exec", 64'({busy, out_id}), 64'({1'b1, 3'd3}));
    #2;
    rst = 1'b0;
    #1;
    chk("rst.async", 64'({out_valid, busy, done_cnt, mul_cfg, out_id}), 64'd0);
    req_valid = '0;
    tick();
    rst = 1'b1;
    tick();
    $display("txn reset_in_exec cnt=%0d busy=%0b", done_cnt, busy);

    // After reset the pointer restarts at requester 0
    req_valid = 4'b1111;
    #1;
    chk("rst.restart_grant", 64'(req_ready), 64'b0001);
    tick();
    req_valid = '0;
    tick();
    chk("rst.restart_resp", 64'({out_valid, out_id, out_c}), 64'({1'b1, 3'd0, 40'h10}));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("rst.restart_cnt", 64'(done_cnt), 64'd1);
    $display("txn restart id=0 cnt=%0d", done_cnt);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mac_mul_sched.md
Name: mac_mul_sched

Overview:
Round-robin scheduler that shares one quad-configurable 8-bit-lane multiplier datapath among N_REQ requesters. Each requester presents a packed operand set and a width config (single/dual/quad). The scheduler arbitrates, drives the multiplier's registered operand and cfg inputs, captures its combinational product, and returns the tagged result over a valid/ready output channel. It sits between the MAC lane front-ends and the shared multiply block.

Parameters:
N_REQ, 4, number of requesters (2..8)
MAC_CONF_WIDTH, 2, cfg width
MAC_MIN_WIDTH, 8, lane width W
MAC_INT_WIDTH, 5*MAC_MIN_WIDTH, product width
ID_WIDTH, 3, requester-id width, must satisfy ID_WIDTH >= clog2(N_REQ)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
req_valid  in  N_REQ  per-requester request valid
req_ready  out  N_REQ  one-hot grant/accept
req_a  in  N_REQ*4*W  per requester {A3,A2,A1,A0}
req_b  in  N_REQ*W  per requester B0
req_cfg  in  N_REQ*2  per requester cfg: 00 single, 01 dual, 10 quad, 11 illegal
mul_a0..mul_a3  out  W each  registered operands to the multiplier
mul_b0  out  W  registered B operand
mul_cfg  out  2  registered cfg to the multiplier
mul_c  in  MAC_INT_WIDTH  combinational product from the multiplier
out_valid  out  1  result valid
out_ready  in  1  consumer accept
out_c  out  MAC_INT_WIDTH  captured product
out_id  out  ID_WIDTH  index of the granted requester
out_err  out  1  request had illegal cfg
busy  out  1  high when state != IDLE
done_cnt  out  16  completed-transaction counter, wraps

Behaviour:
- Reset (rst low, async): state=IDLE. All mul_* outputs, out_c, out_id, out_err, out_valid, done_cnt are 0. The RR pointer is 0. Any in-flight transaction is dropped silently.
- States: IDLE -> EXEC -> DONE -> IDLE.
- IDLE:
  - req_ready is the combinational one-hot grant over req_valid, searched starting at the RR pointer (ascending, wrapping).
  - On a grant to i: latch requester i's operands and cfg into the mul_* registers, set out_id=i, set RR pointer=(i+1) mod N_REQ, go to EXEC.
  - With no valid request, remain in IDLE.
- Lane masking at latch:
  - single: A1..A3 forced to 0.
  - dual: A2 and A3 forced to 0.
  - quad: all lanes passed through.
  - illegal (11): all mul_* operands and mul_cfg forced to 0; out_err latched to 1.
- EXEC: one cycle. mul_c is sampled into out_c (forced to 0 if err). Go to DONE.
- DONE:
  - out_valid=1; out_c, out_id and out_err are held stable.
  - On out_valid&&out_ready: increment done_cnt (16-bit wrap at 0xFFFF->0), clear out_valid, go to IDLE.
- req_ready is 0 in every state other than IDLE.
- Minimum latency: grant edge to out_valid = 2 cycles. Maximum throughput is one result per 3 cycles.
- Requests stay pending until granted; a deasserted req_valid simply forfeits that turn.
- The RR pointer advances only on a grant.
- Product width follows cfg:
  - single uses out_c[15:0];
  - dual uses [23:0];
  - quad uses [39:0];
  - upper bits are whatever the datapath returns (0 by datapath contract).

Decomposition:
- Shared package/header (existing const include): cfg encodings CFG_SINGLE/CFG_DUAL/CFG_QUAD/CFG_ILLEGAL, state encodings, lane width constants.
- One sub-module, mac_rr_arbiter: N_REQ-wide round-robin one-hot grant. Inputs: req, pointer. Outputs: grant, grant_idx, any. Purely combinational.
- Pointer and FSM stay in the top level.

Test Plan:
- Single: req 0, A0=0x0F, B0=0x03, cfg=00. Response: out_valid 2 cycles after grant, out_c=0x2D, out_id=0, out_err=0, mul_a1..a3=0.
- Dual: req 2, {A1,A0}={0x12,0x34}, B0=0x56, cfg=01. Response: out_c=0x61D78, out_id=2.
- Quad: req 1, A=0xFFFFFFFF, B0=0xFF, cfg=10. Response: out_c=0xFE_FFFF_FF01.
- Fairness and backpressure:
  - All 4 requesters hold req_valid and out_ready=1. Grants go 0,1,2,3,0 in order, one per 3 cycles; done_cnt=5.
  - Then out_ready=0 for 5 cycles: out_c and out_id stay stable, req_ready=0.
- Illegal cfg and reset:
  - req 3 with cfg=11: out_err=1, out_c=0, mul_cfg=0.
  - Separately, assert rst low while in EXEC: out_valid=0 immediately (async), state IDLE, done_cnt=0.
  - Next grant restarts from requester 0.
